// File: rtl/id_stage_pkg.sv
// Shared decode constants for the ID stage: opcode/funct values, ALU operation
// encoding, instruction field positions and the ID/EX control bundle.
package id_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;
  localparam int FN_MSB  = 5;
  localparam int FN_LSB  = 0;

  localparam int REG_AW = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    alu_op_e alu_op;
  } ctrl_t;

endpackage

// File: rtl/id_stage_regfile.sv
// Register file: two asynchronous read ports with write-first bypass, one
// synchronous write port, $0 hard-wired to zero, asynchronous clear.
module id_stage_regfile
  import id_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  logic [DATA_W-1:0] mem_q [NREGS];

  // Storage array; writes to $0 are dropped so it can never hold a value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != {REG_AW{1'b0}})) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port 1 with same-cycle write-back bypass.
  always_comb begin
    rdata1_o = '0;
    if (raddr1_i == {REG_AW{1'b0}}) begin
      rdata1_o = '0;
    end else if (we_i && (waddr_i == raddr1_i)) begin
      rdata1_o = wdata_i;
    end else begin
      rdata1_o = mem_q[raddr1_i];
    end
  end

  // Read port 2 with same-cycle write-back bypass.
  always_comb begin
    rdata2_o = '0;
    if (raddr2_i == {REG_AW{1'b0}}) begin
      rdata2_o = '0;
    end else if (we_i && (waddr_i == raddr2_i)) begin
      rdata2_o = wdata_i;
    end else begin
      rdata2_o = mem_q[raddr2_i];
    end
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: decoder, register file, early branch resolution,
// hazard stall, one-slot squash after a taken branch, and the ID/EX register.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 8,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   IF_ID_PC,
  input  logic [31:0]       IF_ID_Instruction,
  input  logic              WB_RegWrite,
  input  logic [4:0]        WB_Rd,
  input  logic [DATA_W-1:0] WB_Data,
  input  logic [4:0]        EX_MEM_Rd,
  input  logic              EX_MEM_MemRead,
  output logic [PC_W-1:0]   BranchTarget,
  output logic              BranchTaken,
  output logic              IF_Stall,
  output logic [PC_W-1:0]   ID_EX_PC,
  output logic [DATA_W-1:0] ID_EX_ReadData1,
  output logic [DATA_W-1:0] ID_EX_ReadData2,
  output logic [DATA_W-1:0] ID_EX_Imm,
  output logic [4:0]        ID_EX_Rs,
  output logic [4:0]        ID_EX_Rt,
  output logic [4:0]        ID_EX_Rd,
  output logic              ID_EX_RegWrite,
  output logic              ID_EX_MemRead,
  output logic              ID_EX_MemWrite,
  output logic              ID_EX_MemToReg,
  output logic              ID_EX_ALUSrc,
  output logic [2:0]        ID_EX_ALUOp
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    ctrl_t             ctrl;
  } id_ex_t;

  logic [5:0]        opcode_s;
  logic [5:0]        funct_s;
  logic [4:0]        rs_s;
  logic [4:0]        rt_s;
  logic [4:0]        rd_s;
  logic [15:0]       imm_s;
  logic [DATA_W-1:0] rdata1_s;
  logic [DATA_W-1:0] rdata2_s;

  ctrl_t       dec_ctrl_s;
  logic [4:0]  dec_dest_s;
  logic        dec_valid_s;
  logic        use_rs_s;
  logic        use_rt_s;
  logic        is_beq_s;
  logic        is_bne_s;
  logic        is_j_s;

  logic        load_use_s;
  logic        br_on_alu_s;
  logic        br_on_mem_s;
  logic        stall_s;
  logic        taken_raw_s;
  logic        issue_s;

  logic        squash_q;
  logic        squash_d;
  id_ex_t      id_ex_q;
  id_ex_t      id_ex_d;

  assign opcode_s = IF_ID_Instruction[OPC_MSB:OPC_LSB];
  assign funct_s  = IF_ID_Instruction[FN_MSB:FN_LSB];
  assign rs_s     = IF_ID_Instruction[RS_MSB:RS_LSB];
  assign rt_s     = IF_ID_Instruction[RT_MSB:RT_LSB];
  assign rd_s     = IF_ID_Instruction[RD_MSB:RD_LSB];
  assign imm_s    = IF_ID_Instruction[IMM_MSB:IMM_LSB];

  id_stage_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we_i     (WB_RegWrite),
    .waddr_i  (WB_Rd),
    .wdata_i  (WB_Data),
    .raddr1_i (rs_s),
    .raddr2_i (rt_s),
    .rdata1_o (rdata1_s),
    .rdata2_o (rdata2_s)
  );

  // Decoder: anything unrecognised leaves every default in place and is a NOP.
  always_comb begin
    dec_ctrl_s  = '0;
    dec_dest_s  = 5'd0;
    dec_valid_s = 1'b0;
    use_rs_s    = 1'b0;
    use_rt_s    = 1'b0;
    is_beq_s    = 1'b0;
    is_bne_s    = 1'b0;
    is_j_s      = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_ADD:  begin dec_valid_s = 1'b1; dec_ctrl_s.alu_op = ALU_ADD; end
          FN_SUB:  begin dec_valid_s = 1'b1; dec_ctrl_s.alu_op = ALU_SUB; end
          FN_AND:  begin dec_valid_s = 1'b1; dec_ctrl_s.alu_op = ALU_AND; end
          FN_OR:   begin dec_valid_s = 1'b1; dec_ctrl_s.alu_op = ALU_OR;  end
          FN_SLT:  begin dec_valid_s = 1'b1; dec_ctrl_s.alu_op = ALU_SLT; end
          default: dec_valid_s = 1'b0;
        endcase
        if (dec_valid_s) begin
          dec_ctrl_s.reg_write = 1'b1;
          dec_dest_s           = rd_s;
          use_rs_s             = 1'b1;
          use_rt_s             = 1'b1;
        end else begin
          dec_ctrl_s = '0;
        end
      end
      OP_ADDI: begin
        dec_valid_s          = 1'b1;
        dec_ctrl_s.reg_write = 1'b1;
        dec_ctrl_s.alu_src   = 1'b1;
        dec_dest_s           = rt_s;
        use_rs_s             = 1'b1;
      end
      OP_LW: begin
        dec_valid_s           = 1'b1;
        dec_ctrl_s.reg_write  = 1'b1;
        dec_ctrl_s.mem_read   = 1'b1;
        dec_ctrl_s.mem_to_reg = 1'b1;
        dec_ctrl_s.alu_src    = 1'b1;
        dec_dest_s            = rt_s;
        use_rs_s              = 1'b1;
      end
      OP_SW: begin
        dec_valid_s          = 1'b1;
        dec_ctrl_s.mem_write = 1'b1;
        dec_ctrl_s.alu_src   = 1'b1;
        use_rs_s             = 1'b1;
        use_rt_s             = 1'b1;
      end
      OP_BEQ: begin
        dec_valid_s = 1'b1;
        is_beq_s    = 1'b1;
        use_rs_s    = 1'b1;
        use_rt_s    = 1'b1;
      end
      OP_BNE: begin
        dec_valid_s = 1'b1;
        is_bne_s    = 1'b1;
        use_rs_s    = 1'b1;
        use_rt_s    = 1'b1;
      end
      OP_J: begin
        dec_valid_s = 1'b1;
        is_j_s      = 1'b1;
      end
      default: dec_valid_s = 1'b0;
    endcase
  end

  // Hazards; a squashed slot is never allowed to stall fetch.
  assign load_use_s  = id_ex_q.ctrl.mem_read && (id_ex_q.rd != 5'd0) &&
                       ((use_rs_s && (id_ex_q.rd == rs_s)) || (use_rt_s && (id_ex_q.rd == rt_s)));
  assign br_on_alu_s = (is_beq_s || is_bne_s) && id_ex_q.ctrl.reg_write && (id_ex_q.rd != 5'd0) &&
                       ((id_ex_q.rd == rs_s) || (id_ex_q.rd == rt_s));
  assign br_on_mem_s = (is_beq_s || is_bne_s) && EX_MEM_MemRead && (EX_MEM_Rd != 5'd0) &&
                       ((EX_MEM_Rd == rs_s) || (EX_MEM_Rd == rt_s));
  assign stall_s     = !squash_q && (load_use_s || br_on_alu_s || br_on_mem_s);

  assign taken_raw_s = (is_beq_s && (rdata1_s == rdata2_s)) ||
                       (is_bne_s && (rdata1_s != rdata2_s)) || is_j_s;

  assign IF_Stall     = stall_s;
  assign BranchTaken  = taken_raw_s && !stall_s && !squash_q;
  assign BranchTarget = is_j_s ? PC_W'(IF_ID_Instruction[7:0])
                               : IF_ID_PC + PC_W'(1'b1) + PC_W'(imm_s[7:0]);
  assign squash_d     = BranchTaken;
  assign issue_s      = dec_valid_s && !squash_q && !stall_s;

  // ID/EX next state: a bubble (all zero) unless the slot issues.
  always_comb begin
    id_ex_d = '0;
    if (issue_s) begin
      id_ex_d.pc     = IF_ID_PC;
      id_ex_d.rdata1 = rdata1_s;
      id_ex_d.rdata2 = rdata2_s;
      id_ex_d.imm    = {{(DATA_W-16){imm_s[15]}}, imm_s};
      id_ex_d.rs     = rs_s;
      id_ex_d.rt     = rt_s;
      id_ex_d.rd     = dec_dest_s;
      id_ex_d.ctrl   = dec_ctrl_s;
    end else begin
      id_ex_d = '0;
    end
  end

  // Pipeline register and squash flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_ex_q  <= '0;
      squash_q <= 1'b0;
    end else begin
      id_ex_q  <= id_ex_d;
      squash_q <= squash_d;
    end
  end

  assign ID_EX_PC        = id_ex_q.pc;
  assign ID_EX_ReadData1 = id_ex_q.rdata1;
  assign ID_EX_ReadData2 = id_ex_q.rdata2;
  assign ID_EX_Imm       = id_ex_q.imm;
  assign ID_EX_Rs        = id_ex_q.rs;
  assign ID_EX_Rt        = id_ex_q.rt;
  assign ID_EX_Rd        = id_ex_q.rd;
  assign ID_EX_RegWrite  = id_ex_q.ctrl.reg_write;
  assign ID_EX_MemRead   = id_ex_q.ctrl.mem_read;
  assign ID_EX_MemWrite  = id_ex_q.ctrl.mem_write;
  assign ID_EX_MemToReg  = id_ex_q.ctrl.mem_to_reg;
  assign ID_EX_ALUSrc    = id_ex_q.ctrl.alu_src;
  assign ID_EX_ALUOp     = id_ex_q.ctrl.alu_op;

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage: decode, register file bypass, stalls,
// branch resolution with squash, and asynchronous reset mid-squash.
module tb_id_stage;

  logic        clk;
  logic        rst;
  logic [7:0]  IF_ID_PC;
  logic [31:0] IF_ID_Instruction;
  logic        WB_RegWrite;
  logic [4:0]  WB_Rd;
  logic [31:0] WB_Data;
  logic [4:0]  EX_MEM_Rd;
  logic        EX_MEM_MemRead;
  logic [7:0]  BranchTarget;
  logic        BranchTaken;
  logic        IF_Stall;
  logic [7:0]  ID_EX_PC;
  logic [31:0] ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm;
  logic [4:0]  ID_EX_Rs, ID_EX_Rt, ID_EX_Rd;
  logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_ALUSrc;
  logic [2:0]  ID_EX_ALUOp;

  int n_checks = 0;
  int n_fail   = 0;

  id_stage dut (
    .clk(clk), .rst(rst), .IF_ID_PC(IF_ID_PC), .IF_ID_Instruction(IF_ID_Instruction),
    .WB_RegWrite(WB_RegWrite), .WB_Rd(WB_Rd), .WB_Data(WB_Data),
    .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_MemRead(EX_MEM_MemRead),
    .BranchTarget(BranchTarget), .BranchTaken(BranchTaken), .IF_Stall(IF_Stall),
    .ID_EX_PC(ID_EX_PC), .ID_EX_ReadData1(ID_EX_ReadData1), .ID_EX_ReadData2(ID_EX_ReadData2),
    .ID_EX_Imm(ID_EX_Imm), .ID_EX_Rs(ID_EX_Rs), .ID_EX_Rt(ID_EX_Rt), .ID_EX_Rd(ID_EX_Rd),
    .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite),
    .ID_EX_MemToReg(ID_EX_MemToReg), .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_ALUOp(ID_EX_ALUOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [126:0] id_ex_all();
    return {ID_EX_PC, ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, ID_EX_Rs, ID_EX_Rt, ID_EX_Rd,
            ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_ALUSrc, ID_EX_ALUOp};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; IF_ID_PC = 8'd0; IF_ID_Instruction = 32'd0; WB_RegWrite = 1'b0;
    WB_Rd = 5'd0; WB_Data = 32'd0; EX_MEM_Rd = 5'd0; EX_MEM_MemRead = 1'b0;
    #12;
    n_checks++; if (id_ex_all() !== 127'd0) begin n_fail++; $display("FAIL reset_id_ex: got %h expected 0", id_ex_all()); end
    n_checks++; if (BranchTaken !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %b expected 0", BranchTaken); end
    n_checks++; if (IF_Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", IF_Stall); end
    #1 rst = 1'b1;
  endtask

  task automatic test_add();
    WB_RegWrite = 1'b1; WB_Rd = 5'd1; WB_Data = 32'd5; step();
    WB_Rd = 5'd2; WB_Data = 32'd7; step();
    WB_RegWrite = 1'b0; IF_ID_PC = 8'd3; IF_ID_Instruction = enc_r(5'd1, 5'd2, 5'd3, 6'h20); step();
    n_checks++; if (ID_EX_ReadData1 !== 32'd5) begin n_fail++; $display("FAIL add_rd1: got %0d expected 5", ID_EX_ReadData1); end
    n_checks++; if (ID_EX_ReadData2 !== 32'd7) begin n_fail++; $display("FAIL add_rd2: got %0d expected 7", ID_EX_ReadData2); end
    n_checks++; if (ID_EX_Rd !== 5'd3) begin n_fail++; $display("FAIL add_dest: got %0d expected 3", ID_EX_Rd); end
    n_checks++; if ({ID_EX_RegWrite, ID_EX_ALUSrc, ID_EX_MemRead} !== 3'b100) begin n_fail++; $display("FAIL add_ctrl: got %b expected 100", {ID_EX_RegWrite, ID_EX_ALUSrc, ID_EX_MemRead}); end
    n_checks++; if (ID_EX_ALUOp !== 3'd0) begin n_fail++; $display("FAIL add_aluop: got %0d expected 0", ID_EX_ALUOp); end
    n_checks++; if (ID_EX_PC !== 8'd3) begin n_fail++; $display("FAIL add_pc: got %0d expected 3", ID_EX_PC); end
    IF_ID_Instruction = enc_r(5'd1, 5'd2, 5'd3, 6'h2A); step();
    n_checks++; if (ID_EX_ALUOp !== 3'd4) begin n_fail++; $display("FAIL slt_aluop: got %0d expected 4", ID_EX_ALUOp); end
    IF_ID_Instruction = enc_r(5'd1, 5'd2, 5'd3, 6'h21); step();
    n_checks++; if (id_ex_all() !== 127'd0) begin n_fail++; $display("FAIL bad_funct_bubble: got %h expected 0", id_ex_all()); end
  endtask

  task automatic test_write_first();
    WB_RegWrite = 1'b1; WB_Rd = 5'd4; WB_Data = 32'hAA;
    IF_ID_PC = 8'd8; IF_ID_Instruction = enc_i(6'h08, 5'd4, 5'd5, 16'hFFFF); step();
    WB_RegWrite = 1'b0;
    n_checks++; if (ID_EX_ReadData1 !== 32'hAA) begin n_fail++; $display("FAIL wf_rd1: got %h expected aa", ID_EX_ReadData1); end
    n_checks++; if (ID_EX_Imm !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wf_imm: got %h expected ffffffff", ID_EX_Imm); end
    n_checks++; if ({ID_EX_ALUSrc, ID_EX_RegWrite} !== 2'b11) begin n_fail++; $display("FAIL wf_ctrl: got %b expected 11", {ID_EX_ALUSrc, ID_EX_RegWrite}); end
    n_checks++; if (ID_EX_Rd !== 5'd5) begin n_fail++; $display("FAIL wf_dest: got %0d expected 5", ID_EX_Rd); end
    IF_ID_Instruction = enc_r(5'd4, 5'd0, 5'd8, 6'h20); step();
    n_checks++; if (ID_EX_ReadData1 !== 32'hAA) begin n_fail++; $display("FAIL wf_stored: got %h expected aa", ID_EX_ReadData1); end
    WB_RegWrite = 1'b1; WB_Rd = 5'd0; WB_Data = 32'h55;
    IF_ID_Instruction = enc_r(5'd0, 5'd0, 5'd8, 6'h20); step();
    WB_RegWrite = 1'b0;
    n_checks++; if (ID_EX_ReadData1 !== 32'd0) begin n_fail++; $display("FAIL r0_zero: got %h expected 0", ID_EX_ReadData1); end
  endtask

  task automatic test_load_use();
    IF_ID_PC = 8'd10; IF_ID_Instruction = enc_i(6'h23, 5'd1, 5'd6, 16'd0); step();
    n_checks++; if ({ID_EX_MemRead, ID_EX_MemToReg, ID_EX_Rd} !== {2'b11, 5'd6}) begin n_fail++; $display("FAIL lw_issue: got %b expected 1100110", {ID_EX_MemRead, ID_EX_MemToReg, ID_EX_Rd}); end
    IF_ID_PC = 8'd11; IF_ID_Instruction = enc_r(5'd6, 5'd1, 5'd7, 6'h20); #1;
    n_checks++; if (IF_Stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b expected 1", IF_Stall); end
    step();
    n_checks++; if (id_ex_all() !== 127'd0) begin n_fail++; $display("FAIL lu_bubble: got %h expected 0", id_ex_all()); end
    n_checks++; if (IF_Stall !== 1'b0) begin n_fail++; $display("FAIL lu_release: got %b expected 0", IF_Stall); end
    step();
    n_checks++; if ({ID_EX_RegWrite, ID_EX_Rd, ID_EX_ReadData2} !== {1'b1, 5'd7, 32'd5}) begin n_fail++; $display("FAIL lu_add_issue: got %h expected %h", {ID_EX_RegWrite, ID_EX_Rd, ID_EX_ReadData2}, {1'b1, 5'd7, 32'd5}); end
    IF_ID_Instruction = enc_i(6'h23, 5'd1, 5'd6, 16'd0); step();
    IF_ID_Instruction = enc_i(6'h08, 5'd1, 5'd6, 16'd1); #1;
    n_checks++; if (IF_Stall !== 1'b0) begin n_fail++; $display("FAIL lu_rt_not_source: got %b expected 0", IF_Stall); end
    step();
  endtask

  task automatic test_branch();
    IF_ID_Instruction = 32'd0; step();
    IF_ID_PC = 8'd16; IF_ID_Instruction = enc_i(6'h04, 5'd1, 5'd1, 16'd3); #1;
    n_checks++; if ({BranchTaken, BranchTarget} !== {1'b1, 8'd20}) begin n_fail++; $display("FAIL beq_taken: got %b/%0d expected 1/20", BranchTaken, BranchTarget); end
    IF_ID_Instruction = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFE); #1;
    n_checks++; if (BranchTarget !== 8'd15) begin n_fail++; $display("FAIL beq_back: got %0d expected 15", BranchTarget); end
    step();
    IF_ID_PC = 8'd17; IF_ID_Instruction = enc_i(6'h04, 5'd1, 5'd2, 16'd3);
    EX_MEM_MemRead = 1'b1; EX_MEM_Rd = 5'd1; #1;
    n_checks++; if ({BranchTaken, IF_Stall} !== 2'b00) begin n_fail++; $display("FAIL squash_quiet: got %b expected 00", {BranchTaken, IF_Stall}); end
    step();
    n_checks++; if (id_ex_all() !== 127'd0) begin n_fail++; $display("FAIL squash_bubble: got %h expected 0", id_ex_all()); end
    n_checks++; if (IF_Stall !== 1'b1) begin n_fail++; $display("FAIL br_mem_stall: got %b expected 1", IF_Stall); end
    EX_MEM_MemRead = 1'b0; EX_MEM_Rd = 5'd0; #1;
    n_checks++; if ({BranchTaken, IF_Stall} !== 2'b00) begin n_fail++; $display("FAIL beq_not_taken: got %b expected 00", {BranchTaken, IF_Stall}); end
    IF_ID_PC = 8'd18; IF_ID_Instruction = enc_i(6'h08, 5'd1, 5'd10, 16'd1); step();
    IF_ID_PC = 8'd19; IF_ID_Instruction = enc_i(6'h05, 5'd10, 5'd1, 16'd2); #1;
    n_checks++; if ({BranchTaken, IF_Stall} !== 2'b01) begin n_fail++; $display("FAIL br_alu_stall: got %b expected 01", {BranchTaken, IF_Stall}); end
    step();
    n_checks++; if ({BranchTaken, IF_Stall, BranchTarget} !== {2'b10, 8'd22}) begin n_fail++; $display("FAIL bne_after_stall: got %b/%0d expected 10/22", {BranchTaken, IF_Stall}, BranchTarget); end
    step();
  endtask

  task automatic test_wrap_and_jump();
    IF_ID_Instruction = 32'd0; step();
    IF_ID_PC = 8'd250; IF_ID_Instruction = enc_i(6'h05, 5'd1, 5'd2, 16'd10); #1;
    n_checks++; if ({BranchTaken, BranchTarget} !== {1'b1, 8'd5}) begin n_fail++; $display("FAIL bne_wrap: got %b/%0d expected 1/5", BranchTaken, BranchTarget); end
    step();
    IF_ID_Instruction = 32'd0; step();
    IF_ID_PC = 8'd30; IF_ID_Instruction = {6'h02, 26'h40}; #1;
    n_checks++; if ({BranchTaken, BranchTarget} !== {1'b1, 8'h40}) begin n_fail++; $display("FAIL jump: got %b/%h expected 1/40", BranchTaken, BranchTarget); end
    step();
    IF_ID_Instruction = 32'd0; step();
  endtask

  task automatic test_reset_mid_squash();
    IF_ID_PC = 8'd16; IF_ID_Instruction = enc_i(6'h04, 5'd1, 5'd1, 16'd3); step();
    n_checks++; if (ID_EX_PC !== 8'd16) begin n_fail++; $display("FAIL pre_reset_pc: got %0d expected 16", ID_EX_PC); end
    IF_ID_PC = 8'd17; IF_ID_Instruction = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    #2 rst = 1'b0; #1;
    n_checks++; if (id_ex_all() !== 127'd0) begin n_fail++; $display("FAIL async_reset_id_ex: got %h expected 0", id_ex_all()); end
    n_checks++; if ({BranchTaken, IF_Stall} !== 2'b00) begin n_fail++; $display("FAIL async_reset_flags: got %b expected 00", {BranchTaken, IF_Stall}); end
    #2 rst = 1'b1;
    step();
    n_checks++; if ({ID_EX_RegWrite, ID_EX_Rd} !== {1'b1, 5'd3}) begin n_fail++; $display("FAIL post_reset_issue: got %b expected 100011", {ID_EX_RegWrite, ID_EX_Rd}); end
    n_checks++; if ({ID_EX_ReadData1, ID_EX_ReadData2} !== 64'd0) begin n_fail++; $display("FAIL regfile_cleared: got %h expected 0", {ID_EX_ReadData1, ID_EX_ReadData2}); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_write_first();
    test_load_use();
    test_branch();
    test_wrap_and_jump();
    test_reset_mid_squash();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
